// File: rtl/a2d_scan_seq.sv
// Autonomous ADC channel scanner: issues one conversion at a time to the A2D SPI
// front end, averages 2^AVG_LOG2 samples per channel and watches for hung conversions.
//
// state | meaning
// IDLE  | waiting for a period tick with en=1
// START | one-cycle strt_cnv request on chnnl
// CONV  | waiting for cnv_cmplt or timeout
// EVAL  | decide: another sample, or commit the average
// NEXT  | advance to the next enabled channel or finish the scan
module a2d_scan_seq #(
    parameter logic [7:0] CHNL_MASK = 8'hFF,
    parameter int         PERIOD    = 1024,
    parameter int         AVG_LOG2  = 2,
    parameter int         TMO       = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [15:0] res,
    input  logic [2:0]  rd_chnl,
    output logic [11:0] rd_data,
    output logic        rd_vld,
    output logic        scan_done,
    output logic        tmo_err,
    input  logic        clr_err
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int PER_W = $clog2(PERIOD);
    localparam int TMO_W = $clog2(TMO + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
    localparam logic [CNT_W-1:0] N_SMP    = CNT_W'(1 << AVG_LOG2);

    typedef enum logic [2:0] {IDLE, START, CONV, EVAL, NEXT} state_t;

    state_t             state, state_nxt;
    logic [PER_W-1:0]   per_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   smp_cnt;
    logic [11:0]        result [8];
    logic [7:0]         valid;

    logic       tick;
    logic [2:0] first_ch, next_ch;
    logic       has_next;
    logic       ld_first, ld_next, acc_add, acc_clr, wr_res;
    logic       tmo_clr, tmo_inc, tmo_hit;
    logic       unused_res;

    assign unused_res = ^res[15:12];
    assign tick       = en && (per_cnt == PER_LAST);
    assign rd_data    = result[rd_chnl];
    assign rd_vld     = valid[rd_chnl];

    // Lowest enabled channel, and lowest enabled channel strictly above chnnl.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (CHNL_MASK[i]) first_ch = 3'(i);
            if (CHNL_MASK[i] && (i > int'(chnnl))) begin
                next_ch  = 3'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        strt_cnv  = 1'b0;
        scan_done = 1'b0;
        ld_first  = 1'b0;
        ld_next   = 1'b0;
        acc_add   = 1'b0;
        acc_clr   = 1'b0;
        wr_res    = 1'b0;
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (tick && (CHNL_MASK != 8'h00)) begin
                    ld_first  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                strt_cnv  = 1'b1;
                tmo_clr   = 1'b1;
                state_nxt = CONV;
            end
            CONV: begin
                tmo_inc = 1'b1;
                // A completion on the timeout cycle is still a good sample.
                if (cnv_cmplt) begin
                    if (en) begin
                        acc_add   = 1'b1;
                        state_nxt = EVAL;
                    end else begin
                        acc_clr   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    acc_clr   = 1'b1;
                    state_nxt = en ? NEXT : IDLE;
                end
            end
            EVAL: begin
                if (!en) begin
                    acc_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (smp_cnt < N_SMP) begin
                    state_nxt = START;
                end else begin
                    wr_res    = 1'b1;
                    acc_clr   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (has_next) begin
                    ld_next   = 1'b1;
                    state_nxt = START;
                end else begin
                    scan_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            chnnl   <= '0;
            tmo_cnt <= '0;
            acc     <= '0;
            smp_cnt <= '0;
            valid   <= '0;
            tmo_err <= 1'b0;
            for (int i = 0; i < 8; i++) result[i] <= '0;
        end else begin
            if (!en || tick) per_cnt <= '0;
            else             per_cnt <= per_cnt + 1'b1;

            if (ld_first)     chnnl <= first_ch;
            else if (ld_next) chnnl <= next_ch;

            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;

            if (acc_clr) begin
                acc     <= '0;
                smp_cnt <= '0;
            end else if (acc_add) begin
                acc     <= acc + ACC_W'(res[11:0]);
                smp_cnt <= smp_cnt + 1'b1;
            end

            if (wr_res) begin
                result[chnnl] <= acc[ACC_W-1:AVG_LOG2];
                valid[chnnl]  <= 1'b1;
            end

            // A new timeout outranks a simultaneous clear.
            if (tmo_hit)      tmo_err <= 1'b1;
            else if (clr_err) tmo_err <= 1'b0;
        end
    end

endmodule
